// File: rtl/pla_cos_sweep_if.sv
// rtl/pla_cos_sweep_if.sv - sweep engine <-> pla_cos / readout bundle
// Optional cksum signal is present when PLA_COS_SWEEP_CKSUM_EN is defined.
interface pla_cos_sweep_if #(
  parameter int WI1 = 4,
  parameter int WF1 = 12,
  parameter int WI2 = 2,
  parameter int WF2 = 14,
  parameter int AW  = 8
);
  logic                        start;
  logic signed [WI1+WF1-1:0]   x_out;
  logic signed [WI2+WF2-1:0]   y_in;
  logic                        busy;
  logic                        done;
  logic        [AW-1:0]        wr_idx;
  logic        [AW-1:0]        rd_addr;
  logic signed [WI2+WF2-1:0]   rd_data;
`ifdef PLA_COS_SWEEP_CKSUM_EN
  logic        [15:0]          cksum;
`endif

  modport master (
    input  start, y_in, rd_addr,
    output x_out, busy, done, wr_idx, rd_data
`ifdef PLA_COS_SWEEP_CKSUM_EN
    , output cksum
`endif
  );

  modport slave (
    output start, y_in, rd_addr,
    input  x_out, busy, done, wr_idx, rd_data
`ifdef PLA_COS_SWEEP_CKSUM_EN
    , input cksum
`endif
  );
endinterface

// File: rtl/pla_cos_sweep.sv
// rtl/pla_cos_sweep.sv - fixed-step phase sweep driver with per-step capture buffer
// Optional running checksum of captured samples: PLA_COS_SWEEP_CKSUM_EN.
module pla_cos_sweep #(
  parameter int WI1  = 4,
  parameter int WF1  = 12,
  parameter int WI2  = 2,
  parameter int WF2  = 14,
  parameter int STEP = 100,
  parameter int NPTS = 256,
  parameter int HOLD = 4,
  parameter int LAT  = 3,
  parameter int AW   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  pla_cos_sweep_if.master  bus
);
  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  generate
    if (HOLD < LAT + 1) begin : g_bad_hold
      $error("pla_cos_sweep: HOLD must be at least LAT+1");
    end
    if (NPTS != 2**AW) begin : g_bad_depth
      $error("pla_cos_sweep: NPTS must equal 2**AW");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic signed [W1-1:0]  r_x_out;
  logic                  r_busy;
  logic                  r_done;
  logic        [AW-1:0]  r_wr_idx;
  logic        [CW-1:0]  r_cnt;
  logic signed [W2-1:0]  r_rd_data;
  logic signed [W2-1:0]  r_buf [NPTS];

  logic w_go;
  logic w_wr;
  logic w_last;

  // start only matters outside RUN; a pulse mid-sweep must not disturb it
  assign w_go   = bus.start && (r_state != S_RUN);
  assign w_wr   = (r_state == S_RUN) && (r_cnt == CW'(HOLD - 1));
  assign w_last = w_wr && (r_wr_idx == AW'(NPTS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (bus.start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_x_out  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_idx <= '0;
      r_cnt    <= '0;
    end else if (w_go) begin
      r_x_out  <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_wr_idx <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      if (w_wr) begin
        r_cnt <= '0;
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
          r_x_out  <= r_x_out + W1'(STEP);
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Capture memory has no reset; its write enable is gated by the reset state
  always_ff @(posedge CLK) begin
    if (w_wr) r_buf[r_wr_idx] <= bus.y_in;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_rd_data <= '0;
    else     r_rd_data <= r_buf[bus.rd_addr];
  end

`ifdef PLA_COS_SWEEP_CKSUM_EN
  logic [15:0] r_cksum;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       r_cksum <= '0;
    else if (w_go) r_cksum <= '0;
    else if (w_wr) r_cksum <= r_cksum + 16'($unsigned(bus.y_in));
  end

  assign bus.cksum = r_cksum;
`endif

  assign bus.x_out   = r_x_out;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.wr_idx  = r_wr_idx;
  assign bus.rd_data = r_rd_data;
endmodule

// File: tb/tb_pla_cos_sweep.sv
// tb/tb_pla_cos_sweep.sv - self-checking bench for pla_cos_sweep (STEP=100 and STEP=400 instances)
// Honours PLA_COS_SWEEP_CKSUM_EN when defined.
module tb_pla_cos_sweep;
  localparam int NOPROBE = -100000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ofs_a  = 0;

  always #5 CLK = ~CLK;

  pla_cos_sweep_if #(.WI1(4), .WF1(12), .WI2(2), .WF2(14), .AW(8)) ifa ();
  pla_cos_sweep_if #(.WI1(4), .WF1(12), .WI2(2), .WF2(14), .AW(8)) ifb ();

  pla_cos_sweep #(.STEP(100)) u_dut_a (.CLK(CLK), .RST(RST), .bus(ifa));
  pla_cos_sweep #(.STEP(400)) u_dut_b (.CLK(CLK), .RST(RST), .bus(ifb));

  // Stand-in for pla_cos: y follows x after LAT=3 edges (plus a per-sweep offset on A)
  logic signed [15:0] dla [3];
  logic signed [15:0] dlb [3];
  always @(posedge CLK) begin
    dla[0] <= ifa.x_out; dla[1] <= dla[0]; dla[2] <= dla[1];
    dlb[0] <= ifb.x_out; dlb[1] <= dlb[0]; dlb[2] <= dlb[1];
  end
  assign ifa.y_in = 16'(int'(dla[2]) + ofs_a);
  assign ifb.y_in = dlb[2];

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic rd(input bit b, input int a, output int v);
    @(negedge CLK);
    if (b) ifb.rd_addr = 8'(a); else ifa.rd_addr = 8'(a);
    @(negedge CLK);
    v = b ? int'(ifb.rd_data) : int'(ifa.rd_data);
  endtask

  task automatic sweep(input bit b, input int extra_at, input int probe_old, output int done_cyc);
    done_cyc = -1;
    @(negedge CLK);
    if (b) ifb.start = 1'b1; else ifa.start = 1'b1;
    @(negedge CLK);
    if (b) ifb.start = 1'b0; else ifa.start = 1'b0;
    if (probe_old != NOPROBE) ifa.rd_addr = 8'd7;
    for (int n = 1; n <= 1100; n++) begin
      if (b) ifb.start = (n == extra_at); else ifa.start = (n == extra_at);
      @(negedge CLK);
      if (probe_old != NOPROBE && n == 32) chk("rd_collide_old", int'(ifa.rd_data), probe_old);
      if (probe_old != NOPROBE && n == 33) chk("rd_collide_new", int'(ifa.rd_data), 700);
      if (n == 500) chk("busy_mid", int'(b ? ifb.busy : ifa.busy), 1);
      if ((b ? ifb.done : ifa.done) && done_cyc < 0) done_cyc = n;
    end
    if (b) ifb.start = 1'b0; else ifa.start = 1'b0;
  endtask

  task automatic check_sweep_a(input string tag, input int ofs, input int nrand);
    int v, k;
    int ks [4] = '{0, 1, 128, 255};
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, ks[i], v);
      chk(tag, v, wrap16(ks[i] * 100 + ofs));
    end
    for (int i = 0; i < nrand; i++) begin
      k = int'($urandom_range(0, 255));
      rd(1'b0, k, v);
      chk(tag, v, wrap16(k * 100 + ofs));
    end
`ifdef PLA_COS_SWEEP_CKSUM_EN
    begin
      int s = 0;
      for (int j = 0; j < 256; j++) s += wrap16(j * 100 + ofs) & 16'hFFFF;
      chk("cksum", int'(ifa.cksum), s % 65536);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, v, ofs1, guard;
    ifa.start = 1'b0; ifb.start = 1'b0;
    ifa.rd_addr = '0; ifb.rd_addr = '0;
    repeat (3) @(negedge CLK);
    chk("rst_x_out",   int'(ifa.x_out),   0);
    chk("rst_busy",    int'(ifa.busy),    0);
    chk("rst_done",    int'(ifa.done),    0);
    chk("rst_wr_idx",  int'(ifa.wr_idx),  0);
    chk("rst_rd_data", int'(ifa.rd_data), 0);
    RST = 1'b0;

    // Sweep 1: random offset on y, plain run
    ofs1  = int'($urandom_range(1, 2000));
    ofs_a = ofs1;
    sweep(1'b0, 0, NOPROBE, dc);
    chk("done_cyc_1", dc, 1024);
    chk("busy_end_1", int'(ifa.busy), 0);
    check_sweep_a("buf_ofs", ofs1, 8);

    // Sweep 2: zero offset, ignored start at RUN cycle 10, read/write collision on addr 7
    ofs_a = 0;
    sweep(1'b0, 10, wrap16(700 + ofs1), dc);
    chk("done_cyc_restart", dc, 1024);
    rd(1'b0, 5, v);
    chk("buf5", v, 500);
    check_sweep_a("buf_zero", 0, 8);

    // Asynchronous abort at wr_idx 40, then a clean sweep
    @(negedge CLK); ifa.start = 1'b1;
    @(negedge CLK); ifa.start = 1'b0;
    guard = 0;
    while (ifa.wr_idx != 8'd40 && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    chk("reach_idx40", int'(ifa.wr_idx), 40);
    RST = 1'b1;
    #1;
    chk("abort_x_out",  int'(ifa.x_out),  0);
    chk("abort_busy",   int'(ifa.busy),   0);
    chk("abort_wr_idx", int'(ifa.wr_idx), 0);
    @(negedge CLK);
    RST = 1'b0;
    sweep(1'b0, 0, NOPROBE, dc);
    chk("done_cyc_after_rst", dc, 1024);
    rd(1'b0, 40, v);
    chk("buf40", v, 4000);

    // STEP=400 instance: x wraps at sample 82
    sweep(1'b1, 0, NOPROBE, dc);
    chk("done_cyc_b", dc, 1024);
    rd(1'b1, 82, v);
    chk("wrap_buf82", v, -32736);
    rd(1'b1, 81, v);
    chk("wrap_buf81", v, 32400);
    for (int i = 0; i < 6; i++) begin
      int k;
      k = int'($urandom_range(0, 255));
      rd(1'b1, k, v);
      chk("wrap_rand", v, wrap16(k * 400));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
